// File: rtl/instr_adder_bk_wrap_pkg.sv
// Shared definitions for the Brent-Kung adder ring wrapper.
// Holds LA1 strobe positions, IO pin positions and LA qualification helpers.
package instr_adder_bk_wrap_pkg;

  localparam int WIDTH = 32;
  localparam int IO_W  = 38;

  localparam int LD_A    = 0;
  localparam int LD_B    = 1;
  localparam int LD_EXT  = 2;
  localparam int LD_RING = 3;
  localparam int LD_SEL  = 4;
  localparam int RUN     = 5;
  localparam int CLR     = 6;

  localparam int RING_PIN  = 8;
  localparam int CARRY_PIN = 9;

  typedef struct packed {
    logic ld_a;
    logic ld_b;
    logic ld_ext;
    logic ld_ring;
    logic ld_sel;
    logic run;
    logic clr;
  } ctrl_t;

  // An LA bit only counts when its active-low enable is asserted.
  function automatic logic [WIDTH-1:0] qualify(input logic [WIDTH-1:0] data,
                                               input logic [WIDTH-1:0] oenb);
    return data & ~oenb;
  endfunction

  function automatic ctrl_t decode_ctrl(input logic [WIDTH-1:0] la1,
                                        input logic             active);
    ctrl_t c;
    c.ld_a    = active & la1[LD_A];
    c.ld_b    = active & la1[LD_B];
    c.ld_ext  = active & la1[LD_EXT];
    c.ld_ring = active & la1[LD_RING];
    c.ld_sel  = active & la1[LD_SEL];
    c.run     = active & la1[RUN];
    c.clr     = active & la1[CLR];
    return c;
  endfunction

endpackage

// File: rtl/instr_adder_bk_wrap_bk_prefix_adder.sv
// Combinational Brent-Kung prefix adder, carry-in 0.
// Up-sweep builds power-of-two group terms, down-sweep fills the remaining carries.
module bk_prefix_adder
  import instr_adder_bk_wrap_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int LOGW = $clog2(W);

  logic [W-1:0] g_s;
  logic [W-1:0] p_s;
  logic [W-1:0] gg_s;
  logic [W-1:0] pp_s;

  // Prefix network: after both sweeps gg_s[i] is the carry out of bit i.
  always_comb begin
    int step;
    int j;
    g_s  = a & b;
    p_s  = a ^ b;
    gg_s = g_s;
    pp_s = p_s;
    step = 32'sd0;
    j    = 32'sd0;
    for (int l = 0; l < LOGW; l++) begin
      step = 32'sd1 << l;
      for (int i = 0; i < W; i++) begin
        j = (i >= step) ? (i - step) : i;
        if ((i % (2 * step)) == (2 * step - 1)) begin
          gg_s[i] = gg_s[i] | (pp_s[i] & gg_s[j]);
          pp_s[i] = pp_s[i] & pp_s[j];
        end else begin
          gg_s[i] = gg_s[i];
          pp_s[i] = pp_s[i];
        end
      end
    end
    for (int l = LOGW - 2; l >= 0; l--) begin
      step = 32'sd1 << l;
      for (int i = 0; i < W; i++) begin
        j = (i >= step) ? (i - step) : i;
        if ((i >= 2 * step) && ((i % (2 * step)) == (step - 1))) begin
          gg_s[i] = gg_s[i] | (pp_s[i] & gg_s[j]);
          pp_s[i] = pp_s[i] & pp_s[j];
        end else begin
          gg_s[i] = gg_s[i];
          pp_s[i] = pp_s[i];
        end
      end
    end
  end

  assign sum  = p_s ^ {gg_s[W-2:0], 1'b0};
  assign cout = gg_s[W-1];

endmodule

// File: rtl/instr_adder_bk_wrap.sv
// Caravel wrapper: LA-loaded operands and masks around a Brent-Kung adder,
// optionally closed into an inverting ring whose transitions are counted.
module instr_adder_bk_wrap
  import instr_adder_bk_wrap_pkg::*;
(
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              active,
  input  logic [WIDTH-1:0]  la1_data_in,
  output logic [WIDTH-1:0]  la1_data_out,
  input  logic [WIDTH-1:0]  la1_oenb,
  input  logic [WIDTH-1:0]  la2_data_in,
  output logic [WIDTH-1:0]  la2_data_out,
  input  logic [WIDTH-1:0]  la2_oenb,
  input  logic [WIDTH-1:0]  la3_data_in,
  output logic [WIDTH-1:0]  la3_data_out,
  input  logic [WIDTH-1:0]  la3_oenb,
  input  logic [IO_W-1:0]   io_in,
  output logic [IO_W-1:0]   io_out,
  output logic [IO_W-1:0]   io_oeb
);

  logic [WIDTH-1:0] q1_s, q2_s, q3_s;
  ctrl_t            ctrl_s;

  logic [WIDTH-1:0] a_input_q, a_input_d;
  logic [WIDTH-1:0] b_input_q, b_input_d;
  logic [WIDTH-1:0] ext_mask_q, ext_mask_d;
  logic [WIDTH-1:0] ring_mask_q, ring_mask_d;
  logic [WIDTH-1:0] sel_mask_q, sel_mask_d;
  logic [WIDTH-1:0] counter_q, counter_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             chain_q, chain_d;
  logic             ring_q, ring_d;

  logic [WIDTH-1:0] a_eff_s;
  logic [WIDTH-1:0] sum_s;
  logic             cout_s;
  logic             ring_next_s;
  logic             unused_ok;

  assign q1_s   = qualify(la1_data_in, la1_oenb);
  assign q2_s   = qualify(la2_data_in, la2_oenb);
  assign q3_s   = qualify(la3_data_in, la3_oenb);
  assign ctrl_s = decode_ctrl(q1_s, active);

  assign unused_ok = ^io_in;

  // Masks are active-low: a cleared bit lets that source drive the operand.
  assign a_eff_s = (~ext_mask_q & a_input_q) | (~ring_mask_q & {WIDTH{ring_q}});

  bk_prefix_adder #(.W(WIDTH)) u_adder (
    .a    (a_eff_s),
    .b    (b_input_q),
    .sum  (sum_s),
    .cout (cout_s)
  );

  assign ring_next_s = ~|(~sel_mask_q & sum_s);

  // Next-state for operands, masks, result, ring and activity counter.
  always_comb begin
    a_input_d   = a_input_q;
    b_input_d   = b_input_q;
    ext_mask_d  = ext_mask_q;
    ring_mask_d = ring_mask_q;
    sel_mask_d  = sel_mask_q;
    counter_d   = counter_q;
    sum_d       = sum_q;
    chain_d     = chain_q;
    ring_d      = ring_q;

    if (active) begin
      sum_d   = sum_s;
      chain_d = cout_s;
    end else begin
      sum_d   = sum_q;
      chain_d = chain_q;
    end

    if (ctrl_s.ld_a)    a_input_d   = q2_s; else a_input_d   = a_input_q;
    if (ctrl_s.ld_b)    b_input_d   = q3_s; else b_input_d   = b_input_q;
    if (ctrl_s.ld_ext)  ext_mask_d  = q2_s; else ext_mask_d  = ext_mask_q;
    if (ctrl_s.ld_ring) ring_mask_d = q3_s; else ring_mask_d = ring_mask_q;
    if (ctrl_s.ld_sel)  sel_mask_d  = q2_s; else sel_mask_d  = sel_mask_q;

    if (ctrl_s.run) begin
      ring_d = ring_next_s;
    end else begin
      ring_d = ring_q;
    end

    // Clear wins over a coincident ring transition.
    if (ctrl_s.clr) begin
      counter_d = '0;
    end else if (ctrl_s.run && (ring_next_s != ring_q)) begin
      counter_d = counter_q + 32'd1;
    end else begin
      counter_d = counter_q;
    end
  end

  // State registers with asynchronous reset; masks reset to "all sources off".
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      a_input_q   <= '0;
      b_input_q   <= '0;
      ext_mask_q  <= '1;
      ring_mask_q <= '1;
      sel_mask_q  <= '1;
      counter_q   <= '0;
      sum_q       <= '0;
      chain_q     <= 1'b0;
      ring_q      <= 1'b0;
    end else begin
      a_input_q   <= a_input_d;
      b_input_q   <= b_input_d;
      ext_mask_q  <= ext_mask_d;
      ring_mask_q <= ring_mask_d;
      sel_mask_q  <= sel_mask_d;
      counter_q   <= counter_d;
      sum_q       <= sum_d;
      chain_q     <= chain_d;
      ring_q      <= ring_d;
    end
  end

  // Deselected block must present a quiet, tri-stated face to the shared area.
  always_comb begin
    la1_data_out = '0;
    la2_data_out = '0;
    la3_data_out = '0;
    io_out       = '0;
    io_oeb       = '1;
    if (active) begin
      la1_data_out          = counter_q;
      la2_data_out          = sum_q;
      la3_data_out          = {{(WIDTH-1){1'b0}}, chain_q};
      io_out[RING_PIN]      = ring_q;
      io_out[CARRY_PIN]     = chain_q;
      io_oeb[RING_PIN]      = 1'b0;
      io_oeb[CARRY_PIN]     = 1'b0;
    end else begin
      la1_data_out = '0;
      la2_data_out = '0;
      la3_data_out = '0;
      io_out       = '0;
      io_oeb       = '1;
    end
  end

endmodule

// File: tb/tb_instr_adder_bk_wrap.sv
// Scoreboard bench for instr_adder_bk_wrap: a reference model predicts every
// output per cycle, plus directed checks of the key scenarios.
module tb_instr_adder_bk_wrap;

  logic        clk = 1'b0;
  logic        rst;
  logic        active;
  logic [31:0] la1_in, la2_in, la3_in;
  logic [31:0] la1_oenb, la2_oenb, la3_oenb;
  logic [31:0] la1_out, la2_out, la3_out;
  logic [37:0] io_in, io_out, io_oeb;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_a, m_b, m_ext, m_ringm, m_sel, m_cnt, m_sum;
  logic        m_chain, m_ring;
  logic [37:0] oeb_on;

  typedef struct {
    string       tag;
    int          kind;
    logic [63:0] exp;
  } exp_t;
  exp_t sb[$];

  instr_adder_bk_wrap dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .active       (active),
    .la1_data_in  (la1_in),
    .la1_data_out (la1_out),
    .la1_oenb     (la1_oenb),
    .la2_data_in  (la2_in),
    .la2_data_out (la2_out),
    .la2_oenb     (la2_oenb),
    .la3_data_in  (la3_in),
    .la3_data_out (la3_out),
    .la3_oenb     (la3_oenb),
    .io_in        (io_in),
    .io_out       (io_out),
    .io_oeb       (io_oeb)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] obs(input int kind);
    case (kind)
      0: return {32'd0, la1_out};
      1: return {32'd0, la2_out};
      2: return {32'd0, la3_out};
      3: return {26'd0, io_out};
      default: return {26'd0, io_oeb};
    endcase
  endfunction

  task automatic model_reset();
    m_a = 32'd0; m_b = 32'd0; m_cnt = 32'd0; m_sum = 32'd0;
    m_ext = 32'hFFFF_FFFF; m_ringm = 32'hFFFF_FFFF; m_sel = 32'hFFFF_FFFF;
    m_chain = 1'b0; m_ring = 1'b0;
  endtask

  task automatic drive(input logic [31:0] l1, input logic [31:0] l2, input logic [31:0] l3);
    la1_in = l1; la2_in = l2; la3_in = l3;
    la1_oenb = 32'd0; la2_oenb = 32'd0; la3_oenb = 32'd0;
  endtask

  // Predict the post-edge outputs, push them, clock once, then compare.
  task automatic cycle();
    logic [31:0] q1, q2, q3, aeff, s;
    logic        co, nr;
    logic [37:0] eio;
    q1 = la1_in & ~la1_oenb;
    q2 = la2_in & ~la2_oenb;
    q3 = la3_in & ~la3_oenb;
    if (active) begin
      aeff = (~m_ext & m_a) | (~m_ringm & {32{m_ring}});
      {co, s} = {1'b0, aeff} + {1'b0, m_b};
      nr = q1[5] ? ~|(~m_sel & s) : m_ring;
      if (q1[6]) m_cnt = 32'd0;
      else if (q1[5] && (nr != m_ring)) m_cnt = m_cnt + 32'd1;
      m_ring = nr; m_sum = s; m_chain = co;
      if (q1[0]) m_a = q2;
      if (q1[1]) m_b = q3;
      if (q1[2]) m_ext = q2;
      if (q1[3]) m_ringm = q3;
      if (q1[4]) m_sel = q2;
      eio = 38'd0;
      eio[8] = m_ring;
      eio[9] = m_chain;
      sb.push_back('{"sb_la1", 0, {32'd0, m_cnt}});
      sb.push_back('{"sb_la2", 1, {32'd0, m_sum}});
      sb.push_back('{"sb_la3", 2, {63'd0, m_chain}});
      sb.push_back('{"sb_io_out", 3, {26'd0, eio}});
      sb.push_back('{"sb_io_oeb", 4, {26'd0, oeb_on}});
    end else begin
      sb.push_back('{"sb_off_la1", 0, 64'd0});
      sb.push_back('{"sb_off_la2", 1, 64'd0});
      sb.push_back('{"sb_off_la3", 2, 64'd0});
      sb.push_back('{"sb_off_io_out", 3, 64'd0});
      sb.push_back('{"sb_off_io_oeb", 4, {26'd0, 38'h3F_FFFF_FFFF}});
    end
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.tag, obs(e.kind), e.exp);
    end
  endtask

  initial begin
    oeb_on = 38'h3F_FFFF_FFFF;
    oeb_on[9:8] = 2'b00;
    io_in = 38'd0;
    active = 1'b1;
    drive(32'd0, 32'd0, 32'd0);
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_la1", {32'd0, la1_out}, 64'd0);
    chk("rst_la2", {32'd0, la2_out}, 64'd0);
    chk("rst_la3", {32'd0, la3_out}, 64'd0);
    chk("rst_io_out", {26'd0, io_out}, 64'd0);
    chk("rst_io_oeb", {26'd0, io_oeb}, {26'd0, oeb_on});
    rst = 1'b0;
    cycle();
    chk("rst_masked_sum", {32'd0, la2_out}, 64'd0);

    // Plain add with external mask opened.
    drive(32'h4, 32'd0, 32'd0); cycle();
    drive(32'h3, 32'd5, 32'd7); cycle();
    drive(32'h0, 32'd0, 32'd0); cycle();
    chk("add_sum", {32'd0, la2_out}, 64'd12);
    chk("add_cout", {32'd0, la3_out}, 64'd0);

    // Overflow.
    drive(32'h3, 32'hFFFF_FFFF, 32'd1); cycle();
    drive(32'h0, 32'd0, 32'd0); cycle();
    chk("ovf_sum", {32'd0, la2_out}, 64'd0);
    chk("ovf_la3", {32'd0, la3_out}, 64'd1);
    chk("ovf_io9", {63'd0, io_out[9]}, 64'd1);

    // Ring oscillation through bit 0.
    drive(32'h4, 32'hFFFF_FFFF, 32'd0); cycle();
    drive(32'h58, 32'hFFFF_FFFE, 32'hFFFF_FFFE); cycle();
    drive(32'h2, 32'd0, 32'd0); cycle();
    drive(32'h20, 32'd0, 32'd0);
    for (int k = 0; k < 10; k++) begin
      cycle();
      chk("ring_toggle", {63'd0, io_out[8]}, (k % 2 == 0) ? 64'd1 : 64'd0);
    end
    chk("ring_cnt", {32'd0, la1_out}, 64'd10);
    drive(32'h40, 32'd0, 32'd0); cycle();
    chk("clr_cnt", {32'd0, la1_out}, 64'd0);

    // Deselect during run.
    drive(32'h20, 32'd0, 32'd0);
    repeat (3) cycle();
    active = 1'b0;
    repeat (5) begin
      cycle();
      chk("off_la1", {32'd0, la1_out}, 64'd0);
    end
    active = 1'b1;
    drive(32'h0, 32'd0, 32'd0); cycle();
    chk("act_cnt_hold", {32'd0, la1_out}, 64'd3);

    // oenb qualification on operand A and on the strobes themselves.
    drive(32'h4, 32'd0, 32'd0); cycle();
    drive(32'h8, 32'd0, 32'hFFFF_FFFF); cycle();
    drive(32'h1, 32'h1234, 32'd0); la2_oenb = 32'hFFFF_FFFF; cycle();
    drive(32'h0, 32'd0, 32'd0); cycle();
    chk("oenb_a", {32'd0, la2_out}, 64'd0);
    drive(32'h1, 32'hFFFF, 32'd0); la2_oenb = 32'h0000_FF00; cycle();
    drive(32'h0, 32'd0, 32'd0); cycle();
    chk("oenb_partial", {32'd0, la2_out}, 64'h00FF);
    drive(32'h1, 32'h55, 32'd0); la1_oenb = 32'hFFFF_FFFF; cycle();
    drive(32'h0, 32'd0, 32'd0); cycle();
    chk("oenb_strobe", {32'd0, la2_out}, 64'h00FF);

    // Random traffic, checked by the model.
    for (int k = 0; k < 40; k++) begin
      la1_in = $urandom & 32'h7F;
      la2_in = $urandom;
      la3_in = $urandom;
      la1_oenb = ($urandom_range(0, 3) == 0) ? $urandom : 32'd0;
      la2_oenb = ($urandom_range(0, 3) == 0) ? $urandom : 32'd0;
      la3_oenb = ($urandom_range(0, 3) == 0) ? $urandom : 32'd0;
      active = ($urandom_range(0, 7) != 0);
      cycle();
    end
    active = 1'b1;

    // Asynchronous reset mid-cycle while running.
    drive(32'h20, 32'd0, 32'd0);
    repeat (2) cycle();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_la1", {32'd0, la1_out}, 64'd0);
    chk("arst_la2", {32'd0, la2_out}, 64'd0);
    chk("arst_la3", {32'd0, la3_out}, 64'd0);
    chk("arst_io_out", {26'd0, io_out}, 64'd0);
    model_reset();
    drive(32'h0, 32'd0, 32'd0);
    #2;
    rst = 1'b0;
    cycle();
    chk("arst_post_sum", {32'd0, la2_out}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_adder_bk_wrap.md
Name: instr_adder_bk_wrap

Overview:
- Caravel user-project wrapper around a 32-bit Brent-Kung prefix adder.
- The adder can be closed into a synchronous inverting feedback "ring" so its activity can be counted on-chip.
- Operands, masks and control come from logic-analyser (LA) inputs; results go out on LA outputs and two IO pins.
- `active` gates the whole block on the shared user area.

Parameters:
- WIDTH, 32, adder/operand/mask width (block is verified only at 32)

Ports:
- wb_clk_i  in  1  clock, rising edge
- wb_rst_i  in  1  reset, asynchronous, active-high
- active  in  1  block enable/select
- la1_data_in  in  32  control strobes (see Behaviour)
- la1_data_out  out  32  activity counter
- la1_oenb  in  32  per-bit LA1 enable, active-low; a bit is accepted only when its oenb=0
- la2_data_in  in  32  operand A / ext mask / output-select data
- la2_data_out  out  32  registered sum
- la2_oenb  in  32  per-bit qualifier for la2_data_in, active-low
- la3_data_in  in  32  operand B / ring mask data
- la3_data_out  out  32  {31'b0, chain_out}
- la3_oenb  in  32  per-bit qualifier for la3_data_in, active-low
- io_in  in  38  unused
- io_out  out  38  [8]=ring_q, [9]=chain_out, others 0
- io_oeb  out  38  [9:8]=0, others 1

Behaviour:
- Input qualification: qualified LA bits are la*_data_in & ~la*_oenb; all uses below refer to qualified values.
- Registers and reset values:
  - a_input, b_input, counter, sum_q: 0
  - a_input_ext_bit_b, a_input_ring_bit_b, s_output_bit_b: all ones
  - chain_out, ring_q: 0
- la1 control bits, all sampled on the rising edge while active=1:
  - [0] a_input <= la2
  - [1] b_input <= la3
  - [2] a_input_ext_bit_b <= la2
  - [3] a_input_ring_bit_b <= la3
  - [4] s_output_bit_b <= la2
  - [5] run
  - [6] counter clear, synchronous
  - [31:7] ignored
  - Simultaneous load strobes all take effect in the same cycle.
- Effective operand: a_eff[i] = (~a_input_ext_bit_b[i] & a_input[i]) | (~a_input_ring_bit_b[i] & ring_q). All masks are active-low.
- Adder: {cout,sum} = a_eff + b_input, carry-in 0, computed by a Brent-Kung prefix network; no `+` operator in the adder core.
- Each cycle while active:
  - sum_q <= sum
  - chain_out <= cout
  - Latency: operand load at edge N gives the result on la2_data_out after edge N+1.
- Ring: when run=1, ring_q <= ~|(~s_output_bit_b & sum). When run=0, ring_q holds.
- Counter:
  - Increments by 1 in each run cycle in which ring_q changes value.
  - Wraps 0xFFFFFFFF -> 0.
  - Clear has priority over increment.
- active=0:
  - All registers hold.
  - la*_data_out = 0 and io_out = 0; io_oeb = all ones.
- Reset mid-operation: all registers return to reset values immediately; run is effectively 0 until la1[5] is reasserted.

Decomposition:
- Shared package holds:
  - WIDTH
  - LA1 control bit indices (LD_A=0, LD_B=1, LD_EXT=2, LD_RING=3, LD_SEL=4, RUN=5, CLR=6)
  - IO pin indices (RING_PIN=8, CARRY_PIN=9)
- One sub-module, bk_prefix_adder: purely combinational 32-bit Brent-Kung adder (a, b -> sum, cout).
- The wrapper holds the registers, masking, ring and counter.

Test Plan:
- Reset (wb_rst_i=1 asynchronously, mid-cycle) -> all LA/IO outputs 0 and io_oeb[9:8]=0, others 1; masks read back as all ones through the adder (sum=b_input=0).
- Add: la2=5, la3=7, la1=0x3 with ext mask cleared (la2=0, la1=0x4 first) -> la2_data_out=12, chain_out=0 one cycle after load.
- Overflow: a=0xFFFFFFFF, b=1, ext mask 0 -> la2_data_out=0, la3_data_out=1, io_out[9]=1.
- Ring oscillation: b=0, ring mask=0xFFFFFFFE, sel mask=0xFFFFFFFE, run for 10 cycles -> ring_q toggles every cycle, la1_data_out=10; clear -> 0 next cycle.
- oenb qualification: la2_oenb=0xFFFFFFFF with load A of 0x1234 -> a_input stays 0.
- active=0 for 5 cycles during run -> outputs 0, counter unchanged after active returns to 1.
